// File: rtl/sram_bist_pkg.sv
// Shared definitions for the SRAM March C- BIST engine.
//   - Controller state encoding (IDLE, RUN, FINAL, DONE).
//   - March element enumeration M0..M5.
//   - Per-element lookup functions: address direction, op count,
//     read background and write background.
//   - Total issue-cycle count for a given address width.
package sram_bist_pkg;

    typedef logic [1:0] bist_state_t;

    localparam bist_state_t ST_IDLE  = 2'd0;
    localparam bist_state_t ST_RUN   = 2'd1;
    localparam bist_state_t ST_FINAL = 2'd2;
    localparam bist_state_t ST_DONE  = 2'd3;

    typedef enum logic [2:0] {
        M0 = 3'd0,
        M1 = 3'd1,
        M2 = 3'd2,
        M3 = 3'd3,
        M4 = 3'd4,
        M5 = 3'd5
    } march_elem_e;

    // Address order: M3 and M4 run downward, all others upward.
    function automatic logic elem_down(input march_elem_e e);
        case (e)
            M3, M4:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Read-then-write elements take two cycles per address.
    function automatic logic elem_two_op(input march_elem_e e);
        case (e)
            M1, M2, M3, M4: return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

    // Background bit expected on reads of this element.
    function automatic logic elem_rbg(input march_elem_e e);
        case (e)
            M2, M4:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Background bit written by this element.
    function automatic logic elem_wbg(input march_elem_e e);
        case (e)
            M1, M3:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Sequencing of march elements; M5 is last and maps to itself.
    function automatic march_elem_e elem_next(input march_elem_e e);
        case (e)
            M0:      return M1;
            M1:      return M2;
            M2:      return M3;
            M3:      return M4;
            M4:      return M5;
            default: return M5;
        endcase
    endfunction

    // Issue cycles: M0 and M5 one per address, M1..M4 two per address.
    function automatic int unsigned total_cycles(input int unsigned aw);
        return 32'd10 << aw;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the March BIST engine.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   load_i        load start address (0 when going up, max when going down)
//   load_down_i   direction used for the load value
//   step_i        advance one address in the direction of dir_down_i
//   dir_down_i    direction of the element currently running
//   addr_o        current address (registered)
//   tc_o          terminal count for the current direction
module sram_bist_addr_gen #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          load_down_i,
    input  logic          step_i,
    input  logic          dir_down_i,
    output logic [AW-1:0] addr_o,
    output logic          tc_o
);

    localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] addr_r;

    // Address register: load has priority over step; never wraps because
    // the controller stops stepping at terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r <= ADDR_ZERO;
        end else if (load_i) begin
            addr_r <= load_down_i ? ADDR_MAX : ADDR_ZERO;
        end else if (step_i) begin
            addr_r <= dir_down_i ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr_o = addr_r;
    assign tc_o   = dir_down_i ? (addr_r == ADDR_ZERO) : (addr_r == ADDR_MAX);

endmodule

// File: rtl/sram_march_bist.sv
// March C- self-test engine and port arbiter for a single-port SRAM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start_i                  start request (honoured in IDLE or DONE)
//   busy_o, done_o, fail_o   test status (done/fail sticky until next start)
//   fail_addr_o, fail_elem_o address and march element of first miscompare
//   func_*                   functional client port, passed through when idle
//   func_gnt_o               client grant (~busy & ~rst)
//   func_rdata_o             SRAM read data to the client
//   mem_*                    SRAM pins; mem_rdata_i valid one cycle after a read
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            fail_o,
    output logic [AW-1:0]   fail_addr_o,
    output logic [2:0]      fail_elem_o,
    input  logic            func_en_i,
    input  logic            func_we_i,
    input  logic [AW-1:0]   func_addr_i,
    input  logic [DW-1:0]   func_wdata_i,
    input  logic [DW/8-1:0] func_be_i,
    output logic            func_gnt_o,
    output logic [DW-1:0]   func_rdata_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic [DW/8-1:0] mem_be_o,
    input  logic [DW-1:0]   mem_rdata_i
);

    bist_state_t   state_r, state_nxt_s;
    logic          busy_r, busy_nxt_s;
    march_elem_e   elem_r, elem_nxt_s;
    logic          phase_r, phase_nxt_s;      // 0 = phase A (read), 1 = phase B (write)
    logic          cmp_pend_r, cmp_pend_nxt_s;
    logic [DW-1:0] exp_r, exp_nxt_s;
    logic [AW-1:0] cmp_addr_r, cmp_addr_nxt_s;
    march_elem_e   cmp_elem_r, cmp_elem_nxt_s;
    logic          done_r, done_nxt_s;
    logic          fail_r, fail_nxt_s;
    logic [AW-1:0] fail_addr_r, fail_addr_nxt_s;
    logic [2:0]    fail_elem_r, fail_elem_nxt_s;

    logic          agen_load_s, agen_load_down_s, agen_step_s, agen_tc_s;
    logic [AW-1:0] agen_addr_s;

    logic          run_s, two_op_s, cur_read_s, miscmp_s;
    logic [DW-1:0] bist_wdata_s;

    sram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (agen_load_s),
        .load_down_i (agen_load_down_s),
        .step_i      (agen_step_s),
        .dir_down_i  (elem_down(elem_r)),
        .addr_o      (agen_addr_s),
        .tc_o        (agen_tc_s)
    );

    assign run_s        = (state_r == ST_RUN);
    assign two_op_s     = elem_two_op(elem_r);
    // Reads are phase A of two-op elements, or every access of M5.
    assign cur_read_s   = run_s & (two_op_s ? ~phase_r : (elem_r == M5));
    assign bist_wdata_s = {DW{elem_wbg(elem_r)}};
    // Compare the read data returned this cycle against last cycle's read.
    assign miscmp_s     = cmp_pend_r & (mem_rdata_i != exp_r);

    // Next-state, sequencing, compare-pipeline and status logic.
    always_comb begin
        state_nxt_s      = state_r;
        elem_nxt_s       = elem_r;
        phase_nxt_s      = phase_r;
        cmp_pend_nxt_s   = 1'b0;
        exp_nxt_s        = exp_r;
        cmp_addr_nxt_s   = cmp_addr_r;
        cmp_elem_nxt_s   = cmp_elem_r;
        done_nxt_s       = done_r;
        fail_nxt_s       = fail_r;
        fail_addr_nxt_s  = fail_addr_r;
        fail_elem_nxt_s  = fail_elem_r;
        agen_load_s      = 1'b0;
        agen_load_down_s = 1'b0;
        agen_step_s      = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_nxt_s     = ST_RUN;
                    elem_nxt_s      = M0;
                    phase_nxt_s     = 1'b0;
                    agen_load_s     = 1'b1;
                    done_nxt_s      = 1'b0;
                    fail_nxt_s      = 1'b0;
                    fail_addr_nxt_s = {AW{1'b0}};
                    fail_elem_nxt_s = 3'd0;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_RUN: begin
                if (miscmp_s) begin
                    // The access presented this cycle still goes out; stop after it.
                    state_nxt_s     = ST_DONE;
                    done_nxt_s      = 1'b1;
                    fail_nxt_s      = 1'b1;
                    fail_addr_nxt_s = cmp_addr_r;
                    fail_elem_nxt_s = cmp_elem_r;
                end else begin
                    cmp_pend_nxt_s = cur_read_s;
                    exp_nxt_s      = {DW{elem_rbg(elem_r)}};
                    cmp_addr_nxt_s = agen_addr_s;
                    cmp_elem_nxt_s = elem_r;
                    if (two_op_s && !phase_r) begin
                        phase_nxt_s = 1'b1;
                    end else begin
                        phase_nxt_s = 1'b0;
                        if (agen_tc_s) begin
                            if (elem_r == M5) begin
                                state_nxt_s = ST_FINAL;
                            end else begin
                                elem_nxt_s       = elem_next(elem_r);
                                agen_load_s      = 1'b1;
                                agen_load_down_s = elem_down(elem_next(elem_r));
                            end
                        end else begin
                            agen_step_s = 1'b1;
                        end
                    end
                end
            end
            ST_FINAL: begin
                // Only the compare of the last M5 read happens here.
                state_nxt_s = ST_DONE;
                done_nxt_s  = 1'b1;
                if (miscmp_s) begin
                    fail_nxt_s      = 1'b1;
                    fail_addr_nxt_s = cmp_addr_r;
                    fail_elem_nxt_s = cmp_elem_r;
                end else begin
                    fail_nxt_s = fail_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign busy_nxt_s = (state_nxt_s == ST_RUN) | (state_nxt_s == ST_FINAL);

    // Controller registers; reset discards any pending compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            elem_r      <= M0;
            phase_r     <= 1'b0;
            cmp_pend_r  <= 1'b0;
            exp_r       <= {DW{1'b0}};
            cmp_addr_r  <= {AW{1'b0}};
            cmp_elem_r  <= M0;
            done_r      <= 1'b0;
            fail_r      <= 1'b0;
            fail_addr_r <= {AW{1'b0}};
            fail_elem_r <= 3'd0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= busy_nxt_s;
            elem_r      <= elem_nxt_s;
            phase_r     <= phase_nxt_s;
            cmp_pend_r  <= cmp_pend_nxt_s;
            exp_r       <= exp_nxt_s;
            cmp_addr_r  <= cmp_addr_nxt_s;
            cmp_elem_r  <= cmp_elem_nxt_s;
            done_r      <= done_nxt_s;
            fail_r      <= fail_nxt_s;
            fail_addr_r <= fail_addr_nxt_s;
            fail_elem_r <= fail_elem_nxt_s;
        end
    end

    // SRAM port arbiter: BIST owns the pins while busy, client otherwise.
    always_comb begin
        if (busy_r) begin
            mem_en_o    = run_s;
            mem_we_o    = run_s & ~cur_read_s;
            mem_addr_o  = agen_addr_s;
            mem_wdata_o = bist_wdata_s;
            mem_be_o    = {(DW/8){1'b1}};
        end else begin
            mem_en_o    = func_en_i;
            mem_we_o    = func_we_i;
            mem_addr_o  = func_addr_i;
            mem_wdata_o = func_wdata_i;
            mem_be_o    = func_be_i;
        end
        if (rst) begin
            mem_en_o = 1'b0;
        end else begin
            mem_en_o = mem_en_o;
        end
    end

    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign fail_o       = fail_r;
    assign fail_addr_o  = fail_addr_r;
    assign fail_elem_o  = fail_elem_r;
    assign func_gnt_o   = ~busy_r & ~rst;
    assign func_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed self-checking bench for sram_march_bist (AW=10, DW=8) with a
// behavioural 1024x8 SRAM that can model bit 3 stuck-at-0 at one address.
module tb_sram_march_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       busy_o, done_o, fail_o;
    logic [9:0] fail_addr_o;
    logic [2:0] fail_elem_o;
    logic       func_en_i, func_we_i;
    logic [9:0] func_addr_i;
    logic [7:0] func_wdata_i;
    logic [0:0] func_be_i;
    logic       func_gnt_o;
    logic [7:0] func_rdata_o;
    logic       mem_en_o, mem_we_o;
    logic [9:0] mem_addr_o;
    logic [7:0] mem_wdata_o;
    logic [0:0] mem_be_o;
    logic [7:0] mem_rdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sram [0:1023];
    logic       stuck_en = 1'b0;
    logic [9:0] stuck_addr = 10'h155;
    logic [7:0] wr_val;

    always #5 clk = ~clk;

    sram_march_bist dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .fail_o(fail_o),
        .fail_addr_o(fail_addr_o), .fail_elem_o(fail_elem_o),
        .func_en_i(func_en_i), .func_we_i(func_we_i), .func_addr_i(func_addr_i),
        .func_wdata_i(func_wdata_i), .func_be_i(func_be_i),
        .func_gnt_o(func_gnt_o), .func_rdata_o(func_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
    );

    // Behavioural SRAM: synchronous write, one-cycle read latency.
    assign wr_val = (stuck_en && mem_addr_o == stuck_addr) ? (mem_wdata_o & 8'hF7) : mem_wdata_o;
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                if (mem_be_o[0]) sram[mem_addr_o] <= wr_val;
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0;
        func_en_i = 1'b1; func_we_i = 1'b0; func_addr_i = 10'h0;
        func_wdata_i = 8'h00; func_be_i = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        n_checks++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done_o); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b expected 0", fail_o); end
        n_checks++; if (fail_addr_o !== 10'h0) begin n_fail++; $display("FAIL reset_fail_addr: got %h expected 000", fail_addr_o); end
        n_checks++; if (fail_elem_o !== 3'd0) begin n_fail++; $display("FAIL reset_fail_elem: got %0d expected 0", fail_elem_o); end
        n_checks++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b expected 0", mem_en_o); end
        n_checks++; if (func_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b expected 0", func_gnt_o); end
        rst = 1'b0; func_en_i = 1'b0;
        tick();
    endtask

    task automatic test_passthrough();
        func_en_i = 1'b1; func_we_i = 1'b1; func_addr_i = 10'h02A;
        func_wdata_i = 8'h5C; func_be_i = 1'b1;
        #1;
        n_checks++; if (func_gnt_o !== 1'b1) begin n_fail++; $display("FAIL pt_gnt: got %b expected 1", func_gnt_o); end
        n_checks++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o} !== {1'b1, 1'b1, 10'h02A, 8'h5C, 1'b1})
            begin n_fail++; $display("FAIL pt_write_pins: got en=%b we=%b a=%h d=%h be=%b expected 1 1 02a 5c 1",
                                     mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o); end
        tick();
        func_we_i = 1'b0;
        tick();
        n_checks++; if (func_rdata_o !== 8'h5C) begin n_fail++; $display("FAIL pt_rdata: got %h expected 5c", func_rdata_o); end
        func_en_i = 1'b0;
        tick();
    endtask

    task automatic test_clean_run();
        int n; int busy_bad; int gnt_bad;
        logic [19:0] first_acc; logic [10:0] m3_rd; logic [18:0] m3_wr; logic [10:0] last_rd; logic final_en;
        busy_bad = 0; gnt_bad = 0;
        // Client keeps requesting a write throughout; it must be ignored.
        func_en_i = 1'b1; func_we_i = 1'b1; func_addr_i = 10'h02A; func_wdata_i = 8'hAA;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (done_o !== 1'b1 && n < 11000) begin
            if (busy_o !== 1'b1) busy_bad++;
            if (func_gnt_o !== 1'b0) gnt_bad++;
            if (n == 1)     first_acc = {mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o};
            if (n == 5121)  m3_rd     = {mem_we_o, mem_addr_o};
            if (n == 5122)  m3_wr     = {mem_we_o, mem_addr_o, mem_wdata_o};
            if (n == 10240) last_rd   = {mem_we_o, mem_addr_o};
            if (n == 10241) final_en  = mem_en_o;
            tick();
            n++;
        end
        func_en_i = 1'b0; func_we_i = 1'b0;
        n_checks++; if (n !== 10242) begin n_fail++; $display("FAIL clean_done_cycle: got %0d expected 10242", n); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL clean_fail: got %b expected 0", fail_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clean_busy_end: got %b expected 0", busy_o); end
        n_checks++; if (busy_bad !== 0) begin n_fail++; $display("FAIL clean_busy_run: got %0d low cycles expected 0", busy_bad); end
        n_checks++; if (gnt_bad !== 0) begin n_fail++; $display("FAIL clean_gnt_run: got %0d grant cycles expected 0", gnt_bad); end
        n_checks++; if (first_acc !== {1'b1, 1'b1, 10'h000, 8'h00}) begin n_fail++; $display("FAIL clean_first_access: got %h expected %h", first_acc, {1'b1, 1'b1, 10'h000, 8'h00}); end
        n_checks++; if (m3_rd !== {1'b0, 10'h3FF}) begin n_fail++; $display("FAIL m3_first_read: got %h expected %h", m3_rd, {1'b0, 10'h3FF}); end
        n_checks++; if (m3_wr !== {1'b1, 10'h3FF, 8'hFF}) begin n_fail++; $display("FAIL m3_first_write: got %h expected %h", m3_wr, {1'b1, 10'h3FF, 8'hFF}); end
        n_checks++; if (last_rd !== {1'b0, 10'h3FF}) begin n_fail++; $display("FAIL m5_last_read: got %h expected %h", last_rd, {1'b0, 10'h3FF}); end
        n_checks++; if (final_en !== 1'b0) begin n_fail++; $display("FAIL final_no_access: got %b expected 0", final_en); end
    endtask

    task automatic test_stuck_fault();
        int n; logic [11:0] det_acc;
        stuck_en = 1'b1; stuck_addr = 10'h155;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (done_o !== 1'b1 && n < 11000) begin
            if (n == 3756) det_acc = {mem_en_o, mem_we_o, mem_addr_o};
            tick();
            n++;
        end
        n_checks++; if (n !== 3757) begin n_fail++; $display("FAIL stuck_done_cycle: got %0d expected 3757", n); end
        n_checks++; if (fail_o !== 1'b1) begin n_fail++; $display("FAIL stuck_fail: got %b expected 1", fail_o); end
        n_checks++; if (fail_elem_o !== 3'd2) begin n_fail++; $display("FAIL stuck_elem: got %0d expected 2", fail_elem_o); end
        n_checks++; if (fail_addr_o !== 10'h155) begin n_fail++; $display("FAIL stuck_addr: got %h expected 155", fail_addr_o); end
        n_checks++; if (det_acc !== {1'b1, 1'b1, 10'h155}) begin n_fail++; $display("FAIL stuck_detect_write: got %h expected %h", det_acc, {1'b1, 1'b1, 10'h155}); end
        n_checks++; if ({busy_o, mem_en_o} !== 2'b00) begin n_fail++; $display("FAIL stuck_stopped: got busy=%b en=%b expected 0 0", busy_o, mem_en_o); end
        tick();
        n_checks++; if ({done_o, fail_o} !== 2'b11) begin n_fail++; $display("FAIL stuck_sticky: got done=%b fail=%b expected 1 1", done_o, fail_o); end
        stuck_en = 1'b0;
    endtask

    task automatic test_restart_after_fail();
        int n;
        start_i = 1'b1;
        tick();
        n_checks++; if ({busy_o, done_o, fail_o} !== 3'b100) begin n_fail++; $display("FAIL restart_status: got busy=%b done=%b fail=%b expected 1 0 0", busy_o, done_o, fail_o); end
        n_checks++; if ({fail_addr_o, fail_elem_o} !== 13'h0) begin n_fail++; $display("FAIL restart_capture_clear: got %h/%0d expected 000/0", fail_addr_o, fail_elem_o); end
        n = 1;
        // start_i stays high for the first 100 cycles of the run and must be ignored.
        while (done_o !== 1'b1 && n < 11000) begin
            if (n == 100) start_i = 1'b0;
            tick();
            n++;
        end
        start_i = 1'b0;
        n_checks++; if (n !== 10242) begin n_fail++; $display("FAIL restart_done_cycle: got %0d expected 10242", n); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL restart_fail: got %b expected 0", fail_o); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 500; i++) tick();
        func_en_i = 1'b1; func_we_i = 1'b0; func_addr_i = 10'h02A;
        rst = 1'b1;
        #1;
        n_checks++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL midrst_mem_en: got %b expected 0", mem_en_o); end
        tick();
        n_checks++; if ({busy_o, done_o} !== 2'b00) begin n_fail++; $display("FAIL midrst_status: got busy=%b done=%b expected 0 0", busy_o, done_o); end
        rst = 1'b0;
        #1;
        n_checks++; if ({func_gnt_o, mem_en_o} !== 2'b11) begin n_fail++; $display("FAIL midrst_func_back: got gnt=%b en=%b expected 1 1", func_gnt_o, mem_en_o); end
        tick();
        func_en_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 1;
        while (done_o !== 1'b1 && n < 11000) begin
            tick();
            n++;
        end
        n_checks++; if (n !== 10242) begin n_fail++; $display("FAIL midrst_rerun_cycle: got %0d expected 10242", n); end
        n_checks++; if (fail_o !== 1'b0) begin n_fail++; $display("FAIL midrst_rerun_fail: got %b expected 0", fail_o); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_clean_run();
        test_stuck_fault();
        test_restart_after_fail();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

March C- built-in self-test engine and port arbiter. It is the initiator for one single-port 1024x8 SRAM wrapper. It drives the wrapper's en/we/be/addr/wdata pins and checks the read data the wrapper returns one cycle after each read. When idle, it passes a functional client straight through to the SRAM. It sits between the memory wrapper and its owning subsystem, so any SRAM instance can be self-tested after power-up.

## Interface
Parameters:
- `AW`, 10: SRAM address width (depth 2**AW).
- `DW`, 8: SRAM data width; must be a multiple of 8.

Ports:
- `clk`  in  1  single clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous active-high reset.
- `start_i`  in  1  level-sampled start request, honoured only in IDLE or DONE.
- `busy_o`  out  1  test in progress; reset 0.
- `done_o`  out  1  test finished; sticky until next accepted start; reset 0.
- `fail_o`  out  1  miscompare detected; sticky with `done_o`; reset 0.
- `fail_addr_o`  out  AW  address of first miscompare; reset 0.
- `fail_elem_o`  out  3  march element (0-5) of first miscompare; reset 0.
- `func_en_i`, `func_we_i`  in  1  functional client request.
- `func_addr_i`  in  AW  functional address.
- `func_wdata_i`  in  DW  functional write data.
- `func_be_i`  in  DW/8  functional byte enables.
- `func_gnt_o`  out  1  equals `~busy_o & ~rst`.
- `func_rdata_o`  out  DW  equals `mem_rdata_i`.
- `mem_en_o`, `mem_we_o`  out  1  SRAM chip enable and write enable, active-high.
- `mem_addr_o`  out  AW  SRAM address.
- `mem_wdata_o`  out  DW  SRAM write data.
- `mem_be_o`  out  DW/8  SRAM byte enables.
- `mem_rdata_i`  in  DW  SRAM read data, valid the cycle after a read access.

## Operation
- States:
  - IDLE → RUN on `start_i`.
  - RUN → FINAL after the last M5 read.
  - RUN → DONE on miscompare.
  - FINAL → DONE.
  - DONE → RUN on `start_i`.
  - Accepting a start clears `done_o`, `fail_o`, `fail_addr_o` and `fail_elem_o`.
- March elements (bg0 = all-zeros, bg1 = all-ones):
  - M0 up (w0).
  - M1 up (r0, w1).
  - M2 up (r1, w0).
  - M3 down (r0, w1).
  - M4 down (r1, w0).
  - M5 up (r0).
  - "Up" runs address 0 to 2**AW-1; "down" runs 2**AW-1 to 0.
- Access timing per address:
  - Single-op elements take 1 cycle.
  - Read-write elements take 2 cycles: read in phase A, write to the same address in phase B.
- BIST accesses always use `mem_be_o` = all ones.
- Read checking:
  - Every BIST read registers an expected value plus a compare-pending flag.
  - The next cycle compares `mem_rdata_i` against the expected value. This cycle is the phase B write, the next element's first access, or FINAL.
- On miscompare:
  - Capture the address and element of the read.
  - Go to DONE with `fail_o` = 1.
  - The write issued in the detection cycle still goes out; no further accesses follow.
- Arbitration:
  - When `busy_o` = 0, `mem_*` = `func_*` combinationally.
  - When `busy_o` = 1, functional requests are ignored (`func_gnt_o` = 0).
  - `mem_en_o` is forced to 0 while `rst` = 1.
- `start_i` while `busy_o` = 1 is ignored.

## Timing
- Start sampled at edge t: the first BIST access (M0, addr 0) is in cycle t+1.
- `busy_o` is high from cycle t+1 through FINAL.
- Issue cycles: 2**AW + 4·2·2**AW + 2**AW = 10240 for AW=10, covering cycles t+1 to t+10240.
- FINAL (last compare) is cycle t+10241.
- Pass: `done_o` = 1 and `busy_o` = 0 from cycle t+10242.
- Miscompare detected in cycle c: `done_o`, `fail_o` and the capture registers are valid from c+1; `busy_o` = 0 from c+1.
- Reset mid-run:
  - State returns to IDLE at the next edge and all status is cleared.
  - Any pending compare is discarded.
  - The functional path regains the SRAM the cycle after `rst` deasserts.
- Address counter wrap: the terminal count (2**AW-1 going up, 0 going down) advances the element. The counter never wraps within an element.

## Structure
- Shared package `sram_bist_pkg`:
  - State enum {IDLE, RUN, FINAL, DONE}.
  - March element enum M0-M5.
  - Per-element constants (direction, op count, read/write backgrounds).
  - Function returning total test cycles for a given AW.
- One sub-module, `sram_bist_addr_gen`: up/down address counter with load, step and terminal-count output.
- The comparator and arbiter mux are inline.

## Test plan
- Clean behavioural SRAM, start at t=0 → `done_o` rises at cycle 10242, `fail_o` = 0, no `func_gnt_o` during run.
- Bit 3 stuck-at-0 at address 0x155 → `fail_o` = 1, `fail_elem_o` = 2, `fail_addr_o` = 0x155, `done_o` one cycle after the failing read's compare.
- Address-order check: first M3 access → `mem_addr_o` = 0x3FF, `mem_we_o` = 0, then 0x3FF with `mem_we_o` = 1 and wdata 0xFF.
- Idle passthrough: `func_we_i` = 1, addr 0x2A, data 0x5C, be = 1 → same values on `mem_*`; a read next cycle returns 0x5C on `func_rdata_o`.
- `rst` pulsed at cycle 500 of a run → `busy_o` = 0 the next cycle, `mem_en_o` = 0 during reset; a new start then completes clean at +10242.
- `start_i` held during run → ignored. Start in DONE after a failing run → `fail_o` clears at the next cycle and the test reruns.
